// File: rtl/mem_resp.sv
// mem_resp: single-port word memory answering a multicycle CPU's memory port.
//
// Each request is accepted from idle, the captured address/data are held while
// a programmable number of wait cycles elapse, then the access is performed and
// a one-cycle ack is returned. The next request can be accepted on the edge
// after ack falls, giving WAIT+3 cycles per access.
//
// Optional feature: define MEM_RESP_ALIGN_CHECK_EN to flag accesses with
// addr[1:0] != 0. Flagged accesses keep normal timing, raise err with ack, and
// neither write memory nor update rdata. Without the macro err is tied to 0 and
// addr[1:0] is ignored.
//
// Parameters:
//   DEPTH_LOG2  word-address width; memory holds 2**DEPTH_LOG2 32-bit words
//   WAIT        wait cycles before each response (0..15)
// Ports:
//   clk    clock, rising edge
//   rst    asynchronous active-high reset (memory contents are not reset)
//   req    access request, held high until ack
//   we     1 = write, 0 = read; sampled at accept
//   addr   byte address; word index is addr[DEPTH_LOG2+1:2]; sampled at accept
//   wdata  write data; sampled at accept
//   rdata  registered read data, updated only by a completed read
//   ack    one-cycle response pulse
//   err    misaligned-access flag, valid while ack=1
//   busy   high whenever the FSM is not idle
module mem_resp #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned WAIT       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int unsigned Words   = 2 ** DEPTH_LOG2;
  localparam logic [3:0]  WaitCnt = 4'(WAIT);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic                    we_q;
  logic                    mis_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [31:0]             wdata_q;

  // Zero at start of simulation; deliberately outside the reset domain.
  logic [31:0] mem [Words] = '{default: 32'h0};

  logic mis_in;
  logic do_access;
  logic mem_write;
  logic unused_addr;

`ifdef MEM_RESP_ALIGN_CHECK_EN
  logic err_q;
  assign mis_in      = |addr[1:0];
  assign err         = err_q;
  assign unused_addr = ^addr[31:DEPTH_LOG2+2];
`else
  assign mis_in      = 1'b0;
  assign err         = 1'b0;
  assign unused_addr = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};
`endif

  assign busy      = (state_q != StIdle);
  // The access happens on the edge that leaves WAIT with the counter exhausted.
  assign do_access = (state_q == StWait) && (cnt_q == 4'd0);
  assign mem_write = do_access && we_q && !mis_q;

  // Reset forces the FSM to idle asynchronously, so an aborted write never
  // reaches this port.
  always_ff @(posedge clk) begin
    if (mem_write) begin
      mem[idx_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      ack     <= 1'b0;
      rdata   <= 32'h0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
`ifdef MEM_RESP_ALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            we_q    <= we;
            mis_q   <= mis_in;
            idx_q   <= addr[DEPTH_LOG2+1:2];
            wdata_q <= wdata;
            cnt_q   <= WaitCnt;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            ack     <= 1'b1;
            state_q <= StResp;
`ifdef MEM_RESP_ALIGN_CHECK_EN
            err_q   <= mis_q;
`endif
            if (!we_q && !mis_q) begin
              rdata <= mem[idx_q];
            end
          end
        end
        StResp: begin
          ack     <= 1'b0;
          state_q <= StIdle;
`ifdef MEM_RESP_ALIGN_CHECK_EN
          err_q   <= 1'b0;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/mem_resp.md
MEM_RESP -- requirements
Module: mem_resp

Interface
REQ-001 Parameter DEPTH_LOG2, default 8, gives the word-address width; the memory holds 2^DEPTH_LOG2 32-bit words.
REQ-002 Parameter WAIT, default 2, gives the number of wait cycles inserted before each response (range 0..15).
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  1  access request from the multicycle controller's memory port, held high until ack.
REQ-006 we  input  1  1 = write, 0 = read; sampled at accept.
REQ-007 addr  input  32  byte address (PC or ALU result selected by iord); sampled at accept.
REQ-008 wdata  input  32  write data (B register); sampled at accept.
REQ-009 rdata  output  32  read data, registered; feeds the IR and DR.
REQ-010 ack  output  1  single-cycle response pulse.
REQ-011 err  output  1  misaligned-access flag, valid only while ack=1.
REQ-012 busy  output  1  high whenever state is not IDLE; combinational from state.

Function
REQ-013 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-014 IDLE: on a rising edge with req=1, the block SHALL capture addr, we and wdata, load cnt=WAIT and enter WAIT; with req=0 it SHALL stay in IDLE.
REQ-015 WAIT: if cnt!=0, cnt SHALL decrement; if cnt==0, the block SHALL perform the access, set ack=1 and enter RESP.
REQ-016 RESP: the block SHALL clear ack and err and return to IDLE; req is not sampled in RESP.
REQ-017 Latency: ack SHALL rise at accept edge + WAIT+1 and stay high for exactly one cycle.
REQ-018 Back-to-back throughput: the next accept SHALL occur no earlier than the edge after ack falls, giving WAIT+3 cycles per access.
REQ-019 Word index SHALL be addr[DEPTH_LOG2+1:2]; upper address bits SHALL be ignored, so addresses wrap modulo memory size.
REQ-020 Read: rdata SHALL be loaded with mem[index] on the edge that sets ack, and SHALL hold that value until the next ack of a read.
REQ-021 Write: mem[index] SHALL be updated on the edge that sets ack; rdata SHALL be unchanged by a write.
REQ-022 A read of a word written by the immediately preceding access SHALL return the new data.
REQ-023 Changes on req, we, addr or wdata after accept SHALL have no effect on the access in progress.
REQ-024 If req is still high in the IDLE cycle after RESP, it SHALL be treated as a new request.

Reset
REQ-025 While rst=1, the block SHALL force state=IDLE, cnt=0, ack=0, err=0, rdata=0 and busy=0, regardless of the clock.
REQ-026 Reset during WAIT SHALL abort the access; a pending write SHALL NOT reach memory.
REQ-027 Memory contents SHALL NOT be altered by reset; contents SHALL be zero at simulation start.
REQ-028 After rst falls, the first accept SHALL be possible on the next rising edge.

Configuration
REQ-029 The feature SHALL be controlled by macro MEM_RESP_ALIGN_CHECK_EN.
REQ-030 Macro defined: an access with addr[1:0]!=0 SHALL complete with normal timing and err=1 during ack; a misaligned write SHALL NOT modify memory and a misaligned read SHALL leave rdata unchanged.
REQ-031 Macro undefined: addr[1:0] SHALL be ignored, err SHALL be tied to 0, and every access SHALL proceed as aligned.

Verification
REQ-032 WAIT=2: write 0x0000_0008 <- 0xDEADBEEF, then read 0x0000_0008 -> rdata=0xDEADBEEF; each ack rises 3 edges after accept; busy is high for 4 cycles per access.
REQ-033 WAIT=0: read 0x0 after reset -> ack in the cycle after accept, rdata=0x00000000; back-to-back reads accepted every 3 cycles.
REQ-034 Wrap: with DEPTH_LOG2=8, write 0x0000_0404 <- 0x12345678, then read 0x0000_0004 -> 0x12345678.
REQ-035 Reset mid-op: write 0x10 <- 0xAAAA5555, assert rst during WAIT -> ack never pulses; a subsequent read of 0x10 -> 0x00000000.
REQ-036 Macro defined: write 0x0000_0006 <- 0x1 -> ack=1 with err=1; a following read of 0x4 -> unchanged; macro undefined: same write -> err=0 and word 0x4 = 0x1.
REQ-037 Hold/ignore: change addr from 0x20 to 0x40 during WAIT of a read -> rdata = mem[0x20]; req held high through RESP -> second accept on the IDLE edge.
